// File: rtl/alu_self_test.sv
// ---------------------------------------------------------------------------
// alu_self_test
//
// In-system stimulus generator and checker for an N-bit, 4-operation ALU.
// A start pulse launches a run of NUM_VECTORS pseudo-random {opcode, A, B}
// vectors taken from a 32-bit LFSR. Each vector is held on the ALU inputs
// for SETTLE_CYCLES cycles. The ALU result is then sampled in a single CHECK
// cycle and compared against an internal reference model. Mismatches are
// counted, and the run ends with a registered pass/fail indication.
//
// Parameters
//   N_PARAMETER    ALU operand/result width (1..15)
//   NUM_VECTORS    vectors per run (>= 1)
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   SEED           LFSR seed; 0 is replaced by 1 so the LFSR never locks up
//   CW             width of err_count / first_fail_idx
//
// Ports
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   start           in   begin a run (accepted only when idle or done)
//   alu_opcode      out  registered opcode to the ALU
//   alu_a, alu_b    out  registered operands to the ALU
//   alu_result      in   combinational ALU result
//   busy            out  run in progress
//   done            out  run finished, held until next accepted start
//   pass            out  valid with done; high iff no mismatches
//   err_count       out  saturating mismatch count
//   first_fail_idx  out  index of first mismatching vector, all-ones if none
// ---------------------------------------------------------------------------
module alu_self_test #(
    parameter int          N_PARAMETER   = 4,
    parameter int          NUM_VECTORS   = 1000,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] SEED          = 32'hACE1_2024,
    parameter int          CW            = $clog2(NUM_VECTORS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [1:0]             alu_opcode,
    output logic [N_PARAMETER-1:0] alu_a,
    output logic [N_PARAMETER-1:0] alu_b,
    input  logic [N_PARAMETER-1:0] alu_result,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CW-1:0]          err_count,
    output logic [CW-1:0]          first_fail_idx
);

    localparam int N = N_PARAMETER;

    // The settle counter only has to reach SETTLE_CYCLES-1.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LAST_IDX    = CW'(NUM_VECTORS - 1);

    // An all-zero seed would freeze a XOR-feedback LFSR.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_reg;
    logic [31:0]   lfsr_reg;
    logic [31:0]   lfsr_next;
    logic [CW-1:0] vec_idx_reg;
    logic [SW-1:0] settle_cnt_reg;
    logic [N-1:0]  ref_result;
    logic          mismatch;
    logic [CW-1:0] err_count_next;

    // Fibonacci LFSR, taps 32,22,2,1.
    // The register shifts left and the feedback bit enters at bit 0.
    assign lfsr_next = {lfsr_reg[30:0],
                        lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};

    // Reference ALU. Arithmetic wraps naturally at N bits.
    always_comb begin
        ref_result = '0;
        case (alu_opcode)
            2'd0:    ref_result = alu_a + alu_b;
            2'd1:    ref_result = alu_a | alu_b;
            2'd2:    ref_result = alu_a - alu_b;
            default: ref_result = alu_a ^ alu_b;
        endcase
    end

    assign mismatch = (alu_result != ref_result);

    // Saturating increment of the mismatch counter.
    assign err_count_next = (err_count == '1) ? err_count : err_count + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            lfsr_reg       <= SEED_EFF;
            vec_idx_reg    <= '0;
            settle_cnt_reg <= '0;
            alu_opcode     <= '0;
            alu_a          <= '0;
            alu_b          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '1;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        err_count      <= '0;
                        first_fail_idx <= '1;
                        vec_idx_reg    <= '0;
                        settle_cnt_reg <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        // Vector 0 comes from the current LFSR value.
                        alu_a          <= lfsr_reg[N-1:0];
                        alu_b          <= lfsr_reg[2*N-1:N];
                        alu_opcode     <= lfsr_reg[31:30];
                        lfsr_reg       <= lfsr_next;
                        state_reg      <= SETTLE;
                    end
                end

                SETTLE: begin
                    settle_cnt_reg <= settle_cnt_reg + SW'(1);
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg <= CHECK;
                    end
                end

                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count_next;
                        if (err_count == '0) begin
                            first_fail_idx <= vec_idx_reg;
                        end
                    end
                    if (vec_idx_reg == LAST_IDX) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        // Fold in this cycle's comparison, because err_count
                        // has not updated yet.
                        pass      <= (err_count == '0) && !mismatch;
                        state_reg <= DONE;
                    end else begin
                        // The next vector loads on the same edge as the
                        // check, so there is no idle gap between vectors.
                        vec_idx_reg    <= vec_idx_reg + CW'(1);
                        settle_cnt_reg <= '0;
                        alu_a          <= lfsr_reg[N-1:0];
                        alu_b          <= lfsr_reg[2*N-1:N];
                        alu_opcode     <= lfsr_reg[31:30];
                        lfsr_reg       <= lfsr_next;
                        state_reg      <= SETTLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_self_test.sv
// ---------------------------------------------------------------------------
// tb_alu_self_test
//
// Bench for alu_self_test. Five instances are used:
//   u_gold  1000 vectors with a golden ALU; used for full runs, start while
//           busy, and reset in the middle of a run
//   u_bad   1000 vectors with an ALU whose result bit 0 is stuck at 0
//   u_sm0/1/2  single-vector instances whose seeds give chosen first
//           vectors: the settle-length case and the subtract/add wrap
//           boundaries
// The bench keeps its own LFSR model, which produces the expected
// operand sequence and the expected results of the faulty-ALU run.
// ---------------------------------------------------------------------------
module tb_alu_self_test;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_gold = 1'b0;
    logic start_bad  = 1'b0;
    logic [2:0] sm_start = 3'b000;

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    function automatic logic [3:0] alu4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a | b;
            2'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    // ---------------- golden 1000-vector instance ----------------
    logic [1:0] gold_op;
    logic [3:0] gold_a, gold_b, gold_res;
    logic       gold_busy, gold_done, gold_pass;
    logic [9:0] gold_err, gold_ffi;
    assign gold_res = alu4(gold_op, gold_a, gold_b);

    alu_self_test #(.N_PARAMETER(4), .NUM_VECTORS(1000), .SETTLE_CYCLES(1),
                    .SEED(32'hACE1_2024)) u_gold (
        .clk(clk), .rst(rst), .start(start_gold),
        .alu_opcode(gold_op), .alu_a(gold_a), .alu_b(gold_b),
        .alu_result(gold_res), .busy(gold_busy), .done(gold_done),
        .pass(gold_pass), .err_count(gold_err), .first_fail_idx(gold_ffi));

    // ---------------- faulty 1000-vector instance ----------------
    logic [1:0] bad_op;
    logic [3:0] bad_a, bad_b, bad_res;
    logic       bad_busy, bad_done, bad_pass;
    logic [9:0] bad_err, bad_ffi;
    assign bad_res = alu4(bad_op, bad_a, bad_b) & 4'hE;

    alu_self_test #(.N_PARAMETER(4), .NUM_VECTORS(1000), .SETTLE_CYCLES(1),
                    .SEED(32'hACE1_2024)) u_bad (
        .clk(clk), .rst(rst), .start(start_bad),
        .alu_opcode(bad_op), .alu_a(bad_a), .alu_b(bad_b),
        .alu_result(bad_res), .busy(bad_busy), .done(bad_done),
        .pass(bad_pass), .err_count(bad_err), .first_fail_idx(bad_ffi));

    // ---------------- single-vector instances ----------------
    wire [2:0][1:0] sm_op;
    wire [2:0][3:0] sm_a, sm_b, sm_res;
    wire [2:0]      sm_busy, sm_done, sm_pass, sm_err, sm_ffi;

    for (genvar gi = 0; gi < 3; gi++) begin : g_sm_alu
        assign sm_res[gi] = alu4(sm_op[gi], sm_a[gi], sm_b[gi]);
    end

    // SEED 1: a=1 b=0 op=0, with a long settle time
    alu_self_test #(.N_PARAMETER(4), .NUM_VECTORS(1), .SETTLE_CYCLES(3),
                    .SEED(32'h0000_0001)) u_sm0 (
        .clk(clk), .rst(rst), .start(sm_start[0]),
        .alu_opcode(sm_op[0]), .alu_a(sm_a[0]), .alu_b(sm_b[0]),
        .alu_result(sm_res[0]), .busy(sm_busy[0]), .done(sm_done[0]),
        .pass(sm_pass[0]), .err_count(sm_err[0]), .first_fail_idx(sm_ffi[0]));

    // a=0 b=1 op=2 : 0-1 wraps to F
    alu_self_test #(.N_PARAMETER(4), .NUM_VECTORS(1), .SETTLE_CYCLES(1),
                    .SEED(32'h8000_0010)) u_sm1 (
        .clk(clk), .rst(rst), .start(sm_start[1]),
        .alu_opcode(sm_op[1]), .alu_a(sm_a[1]), .alu_b(sm_b[1]),
        .alu_result(sm_res[1]), .busy(sm_busy[1]), .done(sm_done[1]),
        .pass(sm_pass[1]), .err_count(sm_err[1]), .first_fail_idx(sm_ffi[1]));

    // a=F b=1 op=0 : F+1 wraps to 0
    alu_self_test #(.N_PARAMETER(4), .NUM_VECTORS(1), .SETTLE_CYCLES(1),
                    .SEED(32'h0000_001F)) u_sm2 (
        .clk(clk), .rst(rst), .start(sm_start[2]),
        .alu_opcode(sm_op[2]), .alu_a(sm_a[2]), .alu_b(sm_b[2]),
        .alu_result(sm_res[2]), .busy(sm_busy[2]), .done(sm_done[2]),
        .pass(sm_pass[2]), .err_count(sm_err[2]), .first_fail_idx(sm_ffi[2]));

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    // Operand sequence model, produced by stepping the LFSR from SEED.
    localparam int MV = 3000;
    logic [1:0] m_op [MV];
    logic [3:0] m_a  [MV];
    logic [3:0] m_b  [MV];

    // Starts a u_gold run, optionally together with u_bad. It compares the
    // operands of every vector against the model, starting at model index
    // base. It pulses start at cycle pulse_cyc and applies reset at cycle
    // rst_cyc; -1 disables either. lat is the number of cycles from the
    // accepting edge until done is seen. It is -1 on timeout and -2 when the
    // run was aborted by reset.
    task automatic run_gold(input int base, input bit with_bad, input int pulse_cyc,
                            input int rst_cyc, output int lat, output int seq_err);
        lat = -1;
        seq_err = 0;
        start_gold = 1'b1;
        start_bad  = with_bad;
        tick();
        start_gold = 1'b0;
        start_bad  = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if ((cyc % 2 == 0) && (cyc / 2 < 1000)) begin
                if (gold_op !== m_op[base + cyc/2] || gold_a !== m_a[base + cyc/2] ||
                    gold_b !== m_b[base + cyc/2])
                    seq_err++;
            end
            if (gold_done) begin
                lat = cyc;
                break;
            end
            if (cyc == pulse_cyc) start_gold = 1'b1;
            if (cyc == rst_cyc) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                lat = -2;
                return;
            end
            tick();
            start_gold = 1'b0;
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        int         lat;
    } vec_t;

    vec_t tbl [3];

    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] l;
        logic [3:0]  r;
        int exp_err, exp_ffi, lat, seq_err, busy_cnt;

        // Expected first vectors of the single-vector instances.
        tbl[0] = '{op: 2'd0, a: 4'h1, b: 4'h0, res: 4'h1, lat: 4};
        tbl[1] = '{op: 2'd2, a: 4'h0, b: 4'h1, res: 4'hF, lat: 2};
        tbl[2] = '{op: 2'd0, a: 4'hF, b: 4'h1, res: 4'h0, lat: 2};

        l = 32'hACE1_2024;
        for (int i = 0; i < MV; i++) begin
            m_a[i]  = l[3:0];
            m_b[i]  = l[7:4];
            m_op[i] = l[31:30];
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        exp_err = 0;
        exp_ffi = -1;
        for (int i = 0; i < 1000; i++) begin
            r = alu4(m_op[i], m_a[i], m_b[i]);
            if (r[0]) begin
                exp_err++;
                if (exp_ffi < 0) exp_ffi = i;
            end
        end
        if (exp_ffi < 0) exp_ffi = 1023;

        // ---- reset state ----
        tick();
        tick();
        rst = 1'b0;
        check("rst_op",   int'(gold_op), 0);
        check("rst_a",    int'(gold_a), 0);
        check("rst_b",    int'(gold_b), 0);
        check("rst_busy", int'(gold_busy), 0);
        check("rst_done", int'(gold_done), 0);
        check("rst_pass", int'(gold_pass), 0);
        check("rst_err",  int'(gold_err), 0);
        check("rst_ffi",  int'(gold_ffi), 1023);
        check("rst_sm_busy", int'(sm_busy), 0);
        check("rst_sm_ffi",  int'(sm_ffi), 7);

        // ---- single-vector table: settle length, wrap boundaries ----
        for (int k = 0; k < 3; k++) begin
            sm_start[k] = 1'b1;
            tick();
            sm_start[k] = 1'b0;
            check($sformatf("sm%0d_op", k),  int'(sm_op[k]),  int'(tbl[k].op));
            check($sformatf("sm%0d_a", k),   int'(sm_a[k]),   int'(tbl[k].a));
            check($sformatf("sm%0d_b", k),   int'(sm_b[k]),   int'(tbl[k].b));
            check($sformatf("sm%0d_res", k), int'(sm_res[k]), int'(tbl[k].res));
            busy_cnt = 0;
            lat = -1;
            for (int c = 0; c < 50; c++) begin
                if (sm_done[k]) begin
                    lat = c;
                    break;
                end
                if (sm_busy[k]) busy_cnt++;
                tick();
            end
            check($sformatf("sm%0d_latency", k), lat, tbl[k].lat);
            check($sformatf("sm%0d_busy_cycles", k), busy_cnt, tbl[k].lat);
            check($sformatf("sm%0d_busy_at_done", k), int'(sm_busy[k]), 0);
            check($sformatf("sm%0d_pass", k), int'(sm_pass[k]), 1);
            check($sformatf("sm%0d_err", k),  int'(sm_err[k]), 0);
            check($sformatf("sm%0d_ffi", k),  int'(sm_ffi[k]), 1);
            check($sformatf("sm%0d_a_held", k), int'(sm_a[k]), int'(tbl[k].a));
        end

        // ---- full golden run, with the faulty ALU run in parallel ----
        run_gold(0, 1'b1, -1, -1, lat, seq_err);
        check("gold_latency", lat, 2000);
        check("gold_vec_seq_errs", seq_err, 0);
        check("gold_pass", int'(gold_pass), 1);
        check("gold_err",  int'(gold_err), 0);
        check("gold_ffi",  int'(gold_ffi), 1023);
        check("gold_busy_at_done", int'(gold_busy), 0);
        check("bad_done", int'(bad_done), 1);
        check("bad_pass", int'(bad_pass), 0);
        check("bad_err",  int'(bad_err), exp_err);
        check("bad_ffi",  int'(bad_ffi), exp_ffi);

        // ---- second run from DONE with a start pulse at vector 10 ----
        run_gold(1000, 1'b0, 20, -1, lat, seq_err);
        check("busy_start_latency", lat, 2000);
        check("busy_start_vec_seq_errs", seq_err, 0);
        check("busy_start_pass", int'(gold_pass), 1);
        check("busy_start_err",  int'(gold_err), 0);

        // ---- reset at vector 500 ----
        run_gold(2000, 1'b0, -1, 1000, lat, seq_err);
        check("abort_flag", lat, -2);
        check("abort_vec_seq_errs", seq_err, 0);
        check("abort_op",   int'(gold_op), 0);
        check("abort_a",    int'(gold_a), 0);
        check("abort_b",    int'(gold_b), 0);
        check("abort_busy", int'(gold_busy), 0);
        check("abort_done", int'(gold_done), 0);
        check("abort_pass", int'(gold_pass), 0);
        check("abort_err",  int'(gold_err), 0);
        check("abort_ffi",  int'(gold_ffi), 1023);

        // start on the same edge as reset: reset wins
        rst = 1'b1;
        start_gold = 1'b1;
        tick();
        rst = 1'b0;
        start_gold = 1'b0;
        check("rst_start_busy", int'(gold_busy), 0);
        tick();
        check("rst_start_idle_busy", int'(gold_busy), 0);

        // After reset, a new run repeats the sequence from SEED.
        run_gold(0, 1'b0, -1, -1, lat, seq_err);
        check("rerun_latency", lat, 2000);
        check("rerun_vec_seq_errs", seq_err, 0);
        check("rerun_pass", int'(gold_pass), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
